// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler for the single register-file write port: round-robin grant,
// registered WE/A3/WD stage, per-register busy scoreboard and RAW hazard report.
module rf_wb_scheduler #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wb_stall,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 hazard,
  output logic [31:0]          busy,
  output logic                 rf_we,
  output logic [4:0]           rf_a3,
  output logic [XLEN-1:0]      rf_wd
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SUMW = IDXW + 1;

  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_a3_q, rf_a3_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;
  logic [31:0]     busy_q, busy_d;

  logic [NREQ-1:0] grant_c;
  logic [IDXW-1:0] gnt_idx_c;
  logic            xfer_c;
  logic [SUMW-1:0] sum_c;
  logic [IDXW-1:0] idx_c;
  logic [4:0]      sel_rd_c;
  logic [XLEN-1:0] sel_data_c;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_c   = '0;
    gnt_idx_c = '0;
    xfer_c    = 1'b0;
    sum_c     = '0;
    idx_c     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_c = {1'b0, ptr_q} + SUMW'(k + 1);
      if (sum_c >= SUMW'(NREQ)) sum_c = sum_c - SUMW'(NREQ);
      idx_c = sum_c[IDXW-1:0];
      if (!wb_stall && !xfer_c && req_valid[idx_c]) begin
        grant_c[idx_c] = 1'b1;
        gnt_idx_c      = idx_c;
        xfer_c         = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rd_c   = '0;
    sel_data_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        sel_rd_c   = req_rd[5*i +: 5];
        sel_data_c = req_data[XLEN*i +: XLEN];
      end
    end
  end

  // Next-state for pointer, write-port stage and scoreboard; a same-edge set beats the clear.
  always_comb begin
    ptr_d   = xfer_c ? gnt_idx_c : ptr_q;
    rf_we_d = xfer_c && (sel_rd_c != 5'd0);
    rf_a3_d = xfer_c ? sel_rd_c : rf_a3_q;
    rf_wd_d = xfer_c ? sel_data_c : rf_wd_q;
    busy_d  = busy_q;
    if (rf_we_q) busy_d[rf_a3_q] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= IDXW'(NREQ - 1);
      rf_we_q <= 1'b0;
      rf_a3_q <= '0;
      rf_wd_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rf_we_q <= rf_we_d;
      rf_a3_q <= rf_a3_d;
      rf_wd_q <= rf_wd_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready = grant_c;
  assign hazard    = busy_q[rs1] | busy_q[rs2];
  assign busy      = busy_q;
  assign rf_we     = rf_we_q;
  assign rf_a3     = rf_a3_q;
  assign rf_wd     = rf_wd_q;

endmodule
